// File: rtl/blink_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared types and helpers for the blink-rate detector.
//   t_Rate   : rate code reported on o_Rate (NONE, 10/5/2/1 Hz)
//   t_State  : detector FSM state, with S_* constants
//   RATE_W   : width of the rate code
//   in_window / win_overlap : classifier window helpers
// -----------------------------------------------------------------------------
package blink_pkg;

  localparam int RATE_W = 3;

  typedef enum logic [RATE_W-1:0] {
    RATE_NONE = 3'd0,
    RATE_10HZ = 3'd1,
    RATE_5HZ  = 3'd2,
    RATE_2HZ  = 3'd3,
    RATE_1HZ  = 3'd4
  } t_Rate;

  typedef logic [1:0] t_State;
  localparam t_State S_IDLE    = 2'd0;
  localparam t_State S_ACQ     = 2'd1;
  localparam t_State S_CONFIRM = 2'd2;
  localparam t_State S_LOCK    = 2'd3;

  // True when n lies in [c - tol, c + tol]; written without subtraction so
  // unsigned underflow cannot occur when c < tol.
  function automatic logic in_window(input int unsigned n,
                                     input int unsigned c,
                                     input int unsigned tol);
    return ((n + tol) >= c) && (n <= (c + tol));
  endfunction

  // Two windows of half-width tol overlap when their centres are 2*tol or less apart.
  function automatic logic win_overlap(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned tol);
    int unsigned diff;
    if (a > b) begin
      diff = a - b;
    end else begin
      diff = b - a;
    end
    return diff <= (32'd2 * tol);
  endfunction

endpackage

// File: rtl/blink_rate_detect_chk.sv
// -----------------------------------------------------------------------------
// blink_rate_detect_chk
// Simulation-only elaboration check: flags any overlap between the four
// classifier windows, which would make classification ambiguous.
// No ports; parameters mirror the detector's class counts and tolerance.
// -----------------------------------------------------------------------------
module blink_rate_detect_chk
  import blink_pkg::*;
#(
  parameter int unsigned g_COUNT_10HZ = 32'd1250000,
  parameter int unsigned g_COUNT_5HZ  = 32'd2500000,
  parameter int unsigned g_COUNT_2HZ  = 32'd6250000,
  parameter int unsigned g_COUNT_1HZ  = 32'd12500000,
  parameter int unsigned g_TOL        = 32'd2
) ();

  localparam logic c_OVERLAP =
      win_overlap(g_COUNT_10HZ, g_COUNT_5HZ, g_TOL) ||
      win_overlap(g_COUNT_10HZ, g_COUNT_2HZ, g_TOL) ||
      win_overlap(g_COUNT_10HZ, g_COUNT_1HZ, g_TOL) ||
      win_overlap(g_COUNT_5HZ,  g_COUNT_2HZ, g_TOL) ||
      win_overlap(g_COUNT_5HZ,  g_COUNT_1HZ, g_TOL) ||
      win_overlap(g_COUNT_2HZ,  g_COUNT_1HZ, g_TOL);

  if (c_OVERLAP) begin : g_overlap
    $error("blink_rate_detect: class windows overlap (g_TOL too large for the class counts)");
  end

endmodule

// File: rtl/sig_edge_detect.sv
// -----------------------------------------------------------------------------
// sig_edge_detect
// Conditions the monitored input and emits a one-cycle strobe for every
// rising or falling edge.
// Build option: BLINK_DET_SYNC_EN inserts a two-flop synchronizer ahead of the
// edge register (strobe latency 3 cycles instead of 1).
// Ports:
//   i_Clk   in  system clock
//   i_Rst_L in  synchronous active-low reset
//   i_Sig   in  monitored square wave
//   o_Edge  out registered edge strobe
// -----------------------------------------------------------------------------
module sig_edge_detect
  import blink_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sig,
  output logic o_Edge
);

  logic w_cond;
  logic r_prev;
  logic r_edge;

`ifdef BLINK_DET_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for an asynchronous input pin.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_Sig;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cond = r_sync2;
`else
  assign w_cond = i_Sig;
`endif

  // Edge history and registered XOR strobe.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_prev <= w_cond;
      r_edge <= w_cond ^ r_prev;
    end
  end

  assign o_Edge = r_edge;

endmodule

// File: rtl/blink_rate_detect.sv
// -----------------------------------------------------------------------------
// blink_rate_detect
// Classifies the toggle rate of a square-wave input as 10/5/2/1 Hz or none.
// Two consecutive matching half-periods are required to lock; a bad interval
// or a stopped input (no edge for 2*g_COUNT_1HZ clocks) drops the lock.
// Build option: BLINK_DET_SYNC_EN (synchronizer in sig_edge_detect).
// Ports:
//   i_Clk      in   system clock
//   i_Rst_L    in   synchronous active-low reset
//   i_Sig      in   monitored square wave
//   o_Rate     out  rate code (0 none, 1 10Hz, 2 5Hz, 3 2Hz, 4 1Hz)
//   o_Valid    out  high while locked
//   o_Rate_Chg out  one-cycle pulse when {o_Valid, o_Rate} changes
// -----------------------------------------------------------------------------
module blink_rate_detect
  import blink_pkg::*;
#(
  parameter int unsigned g_COUNT_10HZ = 32'd1250000,
  parameter int unsigned g_COUNT_5HZ  = 32'd2500000,
  parameter int unsigned g_COUNT_2HZ  = 32'd6250000,
  parameter int unsigned g_COUNT_1HZ  = 32'd12500000,
  parameter int unsigned g_TOL        = 32'd2
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Sig,
  output logic [RATE_W-1:0] o_Rate,
  output logic              o_Valid,
  output logic              o_Rate_Chg
);

  localparam int unsigned c_T  = 32'd2 * g_COUNT_1HZ;
  localparam int          c_CW = $clog2(c_T + 32'd1);
  localparam logic [c_CW-1:0] c_T_CNT = c_CW'(c_T);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

  logic            w_edge;
  logic [c_CW-1:0] r_cnt;
  int unsigned     w_n;
  t_Rate           w_cls;
  t_State          r_state;
  t_State          w_state_nxt;
  t_Rate           r_cand;
  t_Rate           w_cand_nxt;
  logic            w_valid_nxt;
  t_Rate           w_rate_nxt;
  logic            r_valid;
  t_Rate           r_rate;
  logic            r_chg;

  sig_edge_detect u_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sig   (i_Sig),
    .o_Edge  (w_edge)
  );

`ifndef SYNTHESIS
  blink_rate_detect_chk #(
    .g_COUNT_10HZ (g_COUNT_10HZ),
    .g_COUNT_5HZ  (g_COUNT_5HZ),
    .g_COUNT_2HZ  (g_COUNT_2HZ),
    .g_COUNT_1HZ  (g_COUNT_1HZ),
    .g_TOL        (g_TOL)
  ) u_chk ();
`endif

  // Half-period counter: restarts at 1 after each edge, saturates at T.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= c_ONE;
    end else if (r_cnt != c_T_CNT) begin
      r_cnt <= r_cnt + c_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign w_n = 32'(r_cnt);

  // Classifier: at most one window can match because windows never overlap.
  always_comb begin
    w_cls = RATE_NONE;
    if (in_window(w_n, g_COUNT_10HZ, g_TOL)) begin
      w_cls = RATE_10HZ;
    end else if (in_window(w_n, g_COUNT_5HZ, g_TOL)) begin
      w_cls = RATE_5HZ;
    end else if (in_window(w_n, g_COUNT_2HZ, g_TOL)) begin
      w_cls = RATE_2HZ;
    end else if (in_window(w_n, g_COUNT_1HZ, g_TOL)) begin
      w_cls = RATE_1HZ;
    end else begin
      w_cls = RATE_NONE;
    end
  end

  // Next-state logic; a timeout outranks any coincident edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    if ((r_state != S_IDLE) && (r_cnt == c_T_CNT)) begin
      w_state_nxt = S_IDLE;
      w_cand_nxt  = RATE_NONE;
    end else if (w_edge) begin
      case (r_state)
        S_IDLE: begin
          // The first edge only starts a measurement; its interval is meaningless.
          w_state_nxt = S_ACQ;
        end
        S_ACQ: begin
          if (w_cls != RATE_NONE) begin
            w_state_nxt = S_CONFIRM;
            w_cand_nxt  = w_cls;
          end else begin
            w_state_nxt = S_ACQ;
          end
        end
        S_CONFIRM: begin
          if (w_cls == RATE_NONE) begin
            w_state_nxt = S_ACQ;
          end else if (w_cls == r_cand) begin
            w_state_nxt = S_LOCK;
          end else begin
            w_state_nxt = S_CONFIRM;
            w_cand_nxt  = w_cls;
          end
        end
        S_LOCK: begin
          if (w_cls == RATE_NONE) begin
            w_state_nxt = S_ACQ;
          end else if (w_cls == r_cand) begin
            w_state_nxt = S_LOCK;
          end else begin
            w_state_nxt = S_CONFIRM;
            w_cand_nxt  = w_cls;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cand_nxt  = RATE_NONE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
    end
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_rate_nxt  = RATE_NONE;
    if (w_state_nxt == S_LOCK) begin
      w_valid_nxt = 1'b1;
      w_rate_nxt  = w_cand_nxt;
    end else begin
      w_valid_nxt = 1'b0;
      w_rate_nxt  = RATE_NONE;
    end
  end

  // FSM and candidate registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
      r_cand  <= RATE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Registered outputs; the change pulse lands on the same cycle as the update.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_valid <= 1'b0;
      r_rate  <= RATE_NONE;
      r_chg   <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_rate  <= w_rate_nxt;
      r_chg   <= (w_valid_nxt != r_valid) || (w_rate_nxt != r_rate);
    end
  end

  assign o_Rate     = r_rate;
  assign o_Valid    = r_valid;
  assign o_Rate_Chg = r_chg;

endmodule

// File: tb/tb_blink_rate_detect.sv
// -----------------------------------------------------------------------------
// tb_blink_rate_detect
// Directed scenarios followed by a random phase. A reference model built
// from the interval-history rules predicts {o_Valid, o_Rate, o_Rate_Chg}
// every cycle. Works with and without BLINK_DET_SYNC_EN.
// -----------------------------------------------------------------------------
module tb_blink_rate_detect;

  localparam int C10 = 5;
  localparam int C5  = 10;
  localparam int C2  = 25;
  localparam int C1  = 50;
  localparam int TOL = 1;
  localparam int T   = 2 * C1;
`ifdef BLINK_DET_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_l;
  logic       sig;
  logic [2:0] rate;
  logic       valid;
  logic       chg;

  always #5 clk = ~clk;

  blink_rate_detect #(
    .g_COUNT_10HZ (C10),
    .g_COUNT_5HZ  (C5),
    .g_COUNT_2HZ  (C2),
    .g_COUNT_1HZ  (C1),
    .g_TOL        (TOL)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_l),
    .i_Sig      (sig),
    .o_Rate     (rate),
    .o_Valid    (valid),
    .o_Rate_Chg (chg)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: input history (pre-reset samples read as 0),
  // cycles since the last edge, and the classes of the last two intervals.
  logic [7:0] m_hist   = 8'd0;
  bit         m_active = 1'b0;
  int         m_gap    = 0;
  int         m_prev   = 0;
  int         m_last   = 0;
  bit         e_valid  = 1'b0;
  int         e_rate   = 0;
  bit         e_chg    = 1'b0;
  logic       cur_sig  = 1'b0;
  int         chg_seen = 0;
  int         valid_seen = 0;

  function automatic int classify(input int n);
    int c [4];
    c = '{C10, C5, C2, C1};
    for (int i = 0; i < 4; i++) begin
      if (n >= c[i] - TOL && n <= c[i] + TOL) return i + 1;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic s, input logic r);
    bit strobe;
    bit nv;
    int nr;
    sig     = s;
    rst_l   = r;
    cur_sig = s;
    @(posedge clk);
    if (!r) begin
      m_hist   = 8'd0;
      m_active = 1'b0;
      m_gap    = 0;
      m_prev   = 0;
      m_last   = 0;
      e_valid  = 1'b0;
      e_rate   = 0;
      e_chg    = 1'b0;
    end else begin
      strobe = m_hist[D] ^ m_hist[D+1];
      if (m_active && m_gap == T) begin
        m_active = 1'b0;
        m_prev   = 0;
        m_last   = 0;
      end else if (strobe) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_prev   = 0;
          m_last   = 0;
        end else begin
          m_prev = m_last;
          m_last = classify(m_gap);
        end
      end
      m_gap  = strobe ? 1 : ((m_gap < T) ? m_gap + 1 : T);
      nv     = m_active && (m_last != 0) && (m_last == m_prev);
      nr     = nv ? m_last : 0;
      e_chg  = (nv != e_valid) || (nr != e_rate);
      e_valid = nv;
      e_rate  = nr;
      m_hist  = {m_hist[6:0], s};
    end
    #1;
    vectors++;
    assert (valid === e_valid) else begin
      miscompares++;
      $error("FAIL o_Valid @%0t: got %b, expected %b", $time, valid, e_valid);
    end
    assert (rate === 3'(e_rate)) else begin
      miscompares++;
      $error("FAIL o_Rate @%0t: got %0d, expected %0d", $time, rate, e_rate);
    end
    assert (chg === e_chg) else begin
      miscompares++;
      $error("FAIL o_Rate_Chg @%0t: got %b, expected %b", $time, chg, e_chg);
    end
    if (chg === 1'b1) chg_seen++;
    if (valid === 1'b1) valid_seen++;
  endtask

  task automatic hold(input int n);
    repeat (n) step(cur_sig, 1'b1);
  endtask

  // Toggle now, then hold so that the next toggle comes p clocks later.
  task automatic interval(input int p);
    step(~cur_sig, 1'b1);
    repeat (p - 1) step(cur_sig, 1'b1);
  endtask

  initial begin
    int c0;
    int p;
    int sel;
    int cls [4];
    cls = '{C10, C5, C2, C1};

    // Reset
    repeat (3) step(1'b0, 1'b0);
    check("reset_valid", int'(valid), 0);
    check("reset_rate", int'(rate), 0);
    check("reset_chg", int'(chg), 0);
    hold(3);

    // Lock at 10 Hz
    c0 = chg_seen;
    repeat (3) interval(C10);
    check("lock_valid", int'(valid), 1);
    check("lock_rate", int'(rate), 1);
    check("lock_pulses", chg_seen - c0, 1);
    interval(C10);

    // Rate switch to 2 Hz
    c0 = chg_seen;
    repeat (3) interval(C2);
    check("switch_rate", int'(rate), 3);
    check("switch_pulses", chg_seen - c0, 2);

    // Back to 10 Hz, then jitter inside tolerance, then out of tolerance
    repeat (4) interval(C10);
    check("relock10_rate", int'(rate), 1);
    c0 = chg_seen;
    interval(4);
    interval(6);
    interval(5);
    interval(5);
    check("jitter_valid", int'(valid), 1);
    check("jitter_pulses", chg_seen - c0, 0);
    interval(7);
    interval(5);
    check("jitter7_valid", int'(valid), 0);
    check("jitter7_rate", int'(rate), 0);

    // Lock at 1 Hz, then stop the input
    repeat (3) interval(C1);
    check("lock1_rate", int'(rate), 4);
    c0 = chg_seen;
    hold(60);
    check("timeout_valid", int'(valid), 0);
    check("timeout_rate", int'(rate), 0);
    check("timeout_pulses", chg_seen - c0, 1);

    // Out-of-class interval
    c0 = chg_seen;
    valid_seen = 0;
    repeat (8) interval(17);
    check("ooc_valid_seen", valid_seen, 0);
    check("ooc_pulses", chg_seen - c0, 0);

    // Lock at 5 Hz, then a one-cycle reset
    repeat (4) interval(C5);
    check("lock5_rate", int'(rate), 2);
    c0 = chg_seen;
    step(cur_sig, 1'b0);
    check("rst_valid", int'(valid), 0);
    check("rst_rate", int'(rate), 0);
    check("rst_pulses", chg_seen - c0, 0);
    repeat (2) interval(C5);
    check("rst_no_early_lock", int'(valid), 0);
    repeat (2) interval(C5);
    check("rst_relock_rate", int'(rate), 2);

    // Random phase: mostly in-class intervals with jitter, some strays,
    // occasional stops and resets.
    repeat (80) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 14) begin
        p = cls[$urandom_range(0, 3)] + int'($urandom_range(0, 2)) - 1;
        interval(p);
      end else if (sel < 18) begin
        p = int'($urandom_range(2, 60));
        interval(p);
      end else if (sel == 18) begin
        hold(int'($urandom_range(95, 110)));
      end else begin
        step(cur_sig, 1'b0);
      end
    end
    hold(T + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blink_rate_detect.md
# blink_rate_detect

Receive-side counterpart of the LED blinker: monitors one square-wave input, such as a looped-back LED drive or an external blinking source. It classifies the input's toggle rate as one of the four blinker rates (10/5/2/1 Hz) or none. Sits between an input pin and status logic (7-segment or LED display), and lets the board self-check its own blinker outputs.

## Interface
- g_COUNT_10HZ, 1250000: expected half-period in clocks for the 10 Hz class (25 MHz clock).
- g_COUNT_5HZ, 2500000: half-period, 5 Hz class.
- g_COUNT_2HZ, 6250000: half-period, 2 Hz class.
- g_COUNT_1HZ, 12500000: half-period, 1 Hz class.
- g_TOL, 2: allowed deviation, in clocks, of a measured half-period from a class count.
- i_Clk  in  1  system clock; sole clock domain.
- i_Rst_L  in  1  reset; synchronous, active-low.
- i_Sig  in  1  monitored square wave.
- o_Rate  out  3  rate code: 0 = NONE, 1 = 10 Hz, 2 = 5 Hz, 3 = 2 Hz, 4 = 1 Hz.
- o_Valid  out  1  high while locked; o_Rate is meaningful only when high.
- o_Rate_Chg  out  1  one-cycle pulse whenever {o_Valid, o_Rate} changes.

## Operation
- Edge detection: an edge is detected when the conditioned input differs from its previous registered value. Both rising and falling edges count.
- Half-period counter N: cleared to 1 on the cycle after an edge, incremented every cycle otherwise, saturates at T = 2*g_COUNT_1HZ. The measured interval is the number of clocks between consecutive detected edges.
- Classify N: class k matches when |N − g_COUNT_k| ≤ g_TOL; otherwise no match. Class windows must not overlap; a simulation-only elaboration check flags any overlap.
- States:
  - S_IDLE: waiting for the first edge; on an edge go to S_ACQ.
  - S_ACQ: on an edge with a match, store candidate C and go to S_CONFIRM; with no match, stay.
  - S_CONFIRM: on an edge matching C, go to S_LOCK. On an edge matching a different class, replace C and stay. On an edge with no match, go to S_ACQ.
  - S_LOCK: on an edge matching C, stay. On an edge matching another class, set C to the new class and go to S_CONFIRM. On an edge with no match, go to S_ACQ.
- Timeout: in any state except S_IDLE, N reaching T forces S_IDLE.
- Outputs are registered:
  - o_Valid = 1 and o_Rate = C while in S_LOCK.
  - o_Valid = 0 and o_Rate = 0 in every other state.
- o_Rate_Chg: registered compare of the next {o_Valid, o_Rate} against the current value. Both lock and loss of lock pulse it.
- Reset (any time, including mid-lock): state S_IDLE, N = 0, edge-history register = 0. o_Rate = 0, o_Valid = 0, o_Rate_Chg = 0. No o_Rate_Chg pulse is generated by reset itself.

## Timing
- Edge-detect latency from an i_Sig transition: 1 cycle without sync, 3 cycles with sync.
- o_Valid rises 1 cycle after the third detected edge of a clean, in-class signal: two matching intervals are required.
- o_Rate_Chg is coincident with the o_Valid / o_Rate update cycle.
- Loss on a bad interval: o_Valid falls 1 cycle after the offending edge.
- Loss on a stopped signal: o_Valid falls 1 cycle after N reaches T, i.e. T cycles after the last edge.
- Counter width: $clog2(T+1).

## Configuration
- BLINK_DET_SYNC_EN:
  - Defined: i_Sig passes through a two-flop synchronizer before edge detection, so asynchronous pins are safe.
  - Undefined: i_Sig feeds the edge register directly; use only for on-chip, i_Clk-synchronous sources.
- All other behaviour is identical in both builds; only the latency shifts by 2 cycles.

## Structure
- Shared package blink_pkg holds:
  - rate-code typedef t_Rate (RATE_NONE, RATE_10HZ, RATE_5HZ, RATE_2HZ, RATE_1HZ);
  - FSM state typedef;
  - rate-code width constant.
- Sub-module sig_edge_detect: optional synchronizer (under BLINK_DET_SYNC_EN) plus XOR edge detector; outputs a one-cycle edge strobe.
- Top level holds the counter, classifier, FSM and output registers.

## Test plan
Bench parameters: g_COUNT_10HZ = 5, g_COUNT_5HZ = 10, g_COUNT_2HZ = 25, g_COUNT_1HZ = 50, g_TOL = 1, so T = 100. Run every scenario with and without the macro.
- Lock: toggle i_Sig every 5 clocks → after the third edge, o_Valid = 1 and o_Rate = 1, with a single o_Rate_Chg pulse on the same cycle.
- Rate switch: locked at 10 Hz, then toggle every 25 clocks → o_Valid drops after the first 25-clock interval; relocks with o_Rate = 3 after the second; o_Rate_Chg pulses at drop and at relock.
- Jitter: locked at 10 Hz, intervals 4, 6, 5 → stays locked with no o_Rate_Chg. Then an interval of 7 → o_Valid = 0, o_Rate = 0.
- Timeout: locked at 1 Hz (interval 50), then hold i_Sig constant → exactly 100 cycles after the last edge, o_Valid = 0, o_Rate = 0, with one pulse.
- Out-of-class: repeated 17-clock intervals → o_Valid never asserts, o_Rate_Chg never pulses.
- Reset mid-lock: drive i_Rst_L = 0 for 1 cycle while locked at 5 Hz → all outputs 0 on the next cycle, no pulse. Relock requires three fresh edges.
